// File: rtl/date_counter.sv
// Day/month/year counter for the millennium clock. It advances on day_tick,
// accepts a clamped user load, and takes the month length from leap_year_check.
module date_counter #(
  parameter int YEAR_MAX = 974,
  parameter int MONTH_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               day_tick,
  input  logic               load,
  input  logic [4:0]         load_day,
  input  logic [MONTH_W-1:0] load_month,
  input  logic [9:0]         load_year,
  input  logic [4:0]         max_day,
  output logic [4:0]         day,
  output logic [MONTH_W-1:0] month,
  output logic [9:0]         year,
  output logic               year_wrap,
  output logic               busy
);

  typedef enum logic {RUN, CHECK} state_t;

  state_t             state;
  logic               pending;
  logic [4:0]         clamp_day;
  logic [MONTH_W-1:0] clamp_month;
  logic [9:0]         clamp_year;
  logic [4:0]         next_day;
  logic [MONTH_W-1:0] next_month;
  logic [9:0]         next_year;
  logic               next_wrap;

  // A 5-bit load_day can never exceed 31, so only the zero case needs fixing here.
  // The day-against-month clamp happens in CHECK, once max_day follows the new month.
  always_comb begin
    clamp_day   = (load_day == 5'd0) ? 5'd1 : load_day;
    clamp_month = (load_month == '0 || load_month > MONTH_W'(12)) ? MONTH_W'(1) : load_month;
    clamp_year  = (load_year > 10'(YEAR_MAX)) ? 10'(YEAR_MAX) : load_year;
  end

  always_comb begin
    next_day   = day + 5'd1;
    next_month = month;
    next_year  = year;
    next_wrap  = 1'b0;
    if (day >= max_day) begin
      next_day = 5'd1;
      if (month == MONTH_W'(12)) begin
        next_month = MONTH_W'(1);
        if (year == 10'(YEAR_MAX)) begin
          next_year = 10'd0;
          next_wrap = 1'b1;
        end else begin
          next_year = year + 10'd1;
        end
      end else begin
        next_month = month + MONTH_W'(1);
      end
    end
  end

  // A tick that lands in CHECK is remembered in pending and applied on return to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      day       <= 5'd1;
      month     <= MONTH_W'(1);
      year      <= 10'd0;
      year_wrap <= 1'b0;
      busy      <= 1'b0;
      pending   <= 1'b0;
    end else begin
      year_wrap <= 1'b0;
      case (state)
        RUN: begin
          if (load) begin
            day     <= clamp_day;
            month   <= clamp_month;
            year    <= clamp_year;
            pending <= 1'b0;
            state   <= CHECK;
            busy    <= 1'b1;
          end else if (day_tick || pending) begin
            day       <= next_day;
            month     <= next_month;
            year      <= next_year;
            year_wrap <= next_wrap;
            pending   <= 1'b0;
          end
        end
        CHECK: begin
          if (day > max_day) day <= max_day;
          if (day_tick) pending <= 1'b1;
          state <= RUN;
          busy  <= 1'b0;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// Self-checking bench for date_counter: a calendar table, hand-written corner
// sequences and random traffic, all checked against a Gregorian-calendar model.
module tb_date_counter;
  localparam int YEAR_MAX = 974;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       day_tick = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_day = '0;
  logic [5:0] load_month = '0;
  logic [9:0] load_year = '0;
  logic [4:0] max_day;
  logic [4:0] day;
  logic [5:0] month;
  logic [9:0] year;
  logic       year_wrap;
  logic       busy;

  int vectors = 0;
  int errors = 0;
  int wraps_seen = 0;

  int m_day, m_month, m_year;
  bit m_wrap, m_busy, m_pending;

  date_counter #(.YEAR_MAX(YEAR_MAX), .MONTH_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .load(load),
    .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .max_day(max_day), .day(day), .month(month), .year(year),
    .year_wrap(year_wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  // Calendar length from the real Gregorian rules on the absolute year.
  function automatic int days_in(input int mon, input int yoff);
    int y;
    bit leap;
    y = 2025 + yoff;
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    case (mon)
      2:             return leap ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  // Stand-in for leap_year_check, fed from the DUT's month/year outputs.
  always_comb max_day = 5'(days_in(int'(month), int'(year)));

  task automatic resetModel();
    m_day = 1; m_month = 1; m_year = 0;
    m_wrap = 0; m_busy = 0; m_pending = 0;
  endtask

  task automatic modelAdvance();
    m_day++;
    if (m_day > days_in(m_month, m_year)) begin
      m_day = 1;
      m_month++;
      if (m_month > 12) begin
        m_month = 1;
        m_year++;
        if (m_year > YEAR_MAX) begin
          m_year = 0;
          m_wrap = 1;
        end
      end
    end
  endtask

  task automatic modelStep(input bit tick, input bit ld, input int d, input int m, input int y);
    m_wrap = 0;
    if (!m_busy) begin
      if (ld) begin
        m_day   = (d == 0) ? 1 : (d > 31 ? 31 : d);
        m_month = (m == 0 || m > 12) ? 1 : m;
        m_year  = (y > YEAR_MAX) ? YEAR_MAX : y;
        m_busy = 1;
        m_pending = 0;
      end else if (tick || m_pending) begin
        modelAdvance();
        m_pending = 0;
      end
    end else begin
      if (m_day > days_in(m_month, m_year)) m_day = days_in(m_month, m_year);
      if (tick) m_pending = 1;
      m_busy = 0;
    end
  endtask

  task automatic checkOutput(input string name);
    vectors++;
    if (int'(day) != m_day || int'(month) != m_month || int'(year) != m_year ||
        year_wrap != m_wrap || busy != m_busy) begin
      errors++;
      $display("[TB] FAIL %s: got %0d/%0d/%0d wrap=%0b busy=%0b, expected %0d/%0d/%0d wrap=%0b busy=%0b",
               name, day, month, year, year_wrap, busy, m_day, m_month, m_year, m_wrap, m_busy);
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit ld, input int d, input int m,
                               input int y, input string name);
    @(negedge clk);
    day_tick = tick;
    load = ld;
    load_day = 5'(d);
    load_month = 6'(m);
    load_year = 10'(y);
    @(posedge clk);
    modelStep(tick, ld, d, m, y);
    #1;
    if (year_wrap) wraps_seen++;
    checkOutput(name);
    day_tick = 0;
    load = 0;
  endtask

  typedef struct {
    int ld, lm, ly;
    int ticks;
    int ed, em, ey;
    int ewraps;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{28, 2, 0,    1,  1, 3, 0,   0};
    tbl[1] = '{28, 2, 3,    1, 29, 2, 3,   0};
    tbl[2] = '{28, 2, 3,    2,  1, 3, 3,   0};
    tbl[3] = '{28, 2, 75,   1,  1, 3, 75,  0};
    tbl[4] = '{28, 2, 375,  1, 29, 2, 375, 0};
    tbl[5] = '{31, 12, 974, 1,  1, 1, 0,   1};
    tbl[6] = '{31, 12, 5,   1,  1, 1, 6,   0};
    tbl[7] = '{31, 4, 0,    0, 30, 4, 0,   0};
    tbl[8] = '{30, 2, 1,    0, 28, 2, 1,   0};
    tbl[9] = '{0, 13, 1000, 0,  1, 1, 974, 0};

    resetModel();
    #12;
    vectors++;
    if (day != 5'd1 || month != 6'd1 || year != 10'd0 || busy || year_wrap) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %0d/%0d/%0d busy=%0b wrap=%0b, expected 1/1/0 busy=0 wrap=0",
               day, month, year, busy, year_wrap);
    end
    @(negedge clk) rst_n = 1;
    applyStimulus(0, 0, 0, 0, 0, "after_reset");

    foreach (tbl[i]) begin
      wraps_seen = 0;
      applyStimulus(0, 1, tbl[i].ld, tbl[i].lm, tbl[i].ly, $sformatf("tbl%0d_load", i));
      applyStimulus(0, 0, 0, 0, 0, $sformatf("tbl%0d_check", i));
      for (int t = 0; t < tbl[i].ticks; t++)
        applyStimulus(1, 0, 0, 0, 0, $sformatf("tbl%0d_tick%0d", i, t));
      applyStimulus(0, 0, 0, 0, 0, $sformatf("tbl%0d_idle", i));
      vectors++;
      if (int'(day) != tbl[i].ed || int'(month) != tbl[i].em || int'(year) != tbl[i].ey ||
          wraps_seen != tbl[i].ewraps) begin
        errors++;
        $display("[TB] FAIL tbl%0d_result: got %0d/%0d/%0d wraps=%0d, expected %0d/%0d/%0d wraps=%0d",
                 i, day, month, year, wraps_seen, tbl[i].ed, tbl[i].em, tbl[i].ey, tbl[i].ewraps);
      end
    end

    // Tick during CHECK is deferred to the first RUN cycle.
    applyStimulus(0, 1, 30, 6, 0, "defer_load");
    applyStimulus(1, 0, 0, 0, 0, "defer_tick_in_check");
    applyStimulus(0, 0, 0, 0, 0, "defer_applied");
    vectors++;
    if (day != 5'd1 || month != 6'd7 || year != 10'd0) begin
      errors++;
      $display("[TB] FAIL defer_result: got %0d/%0d/%0d, expected 1/7/0", day, month, year);
    end

    // Load wins over a coincident tick; back-to-back ticks give two days.
    applyStimulus(1, 1, 15, 5, 10, "load_and_tick");
    applyStimulus(0, 0, 0, 0, 0, "load_and_tick_check");
    applyStimulus(1, 0, 0, 0, 0, "tick_a");
    applyStimulus(1, 0, 0, 0, 0, "tick_b");

    // Asynchronous reset between edges while pending is set.
    applyStimulus(0, 1, 20, 8, 100, "pend_load");
    applyStimulus(1, 0, 0, 0, 0, "pend_set");
    #2 rst_n = 0;
    #1;
    resetModel();
    checkOutput("async_reset");
    @(negedge clk) rst_n = 1;
    applyStimulus(0, 0, 0, 0, 0, "pending_lost");
    applyStimulus(0, 0, 0, 0, 0, "pending_lost2");

    for (int n = 0; n < 3000; n++) begin
      bit tk, ld;
      int d, m, y;
      tk = ($urandom_range(0, 1) == 1);
      ld = ($urandom_range(0, 15) == 0);
      d = $urandom_range(0, 31);
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(1, 12);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(970, 1023) : $urandom_range(0, 1023);
      if ($urandom_range(0, 7) == 0) begin
        d = 31; m = 12; y = YEAR_MAX;
      end
      applyStimulus(tk, ld, d, m, y, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
